// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - button channel bundle between raw buttons and the conditioner
// Purpose: groups the raw button inputs and the conditioned level/pulse outputs.
// Signals: btn_raw   [N_BTN] raw asynchronous buttons, 1 = pressed
//          btn_level [N_BTN] debounced stable level, 1 = pressed
//          btn_pulse [N_BTN] one-cycle press pulse (plus auto-repeats when enabled)
// Modports: master drives btn_raw; slave (the conditioner) drives btn_level/btn_pulse.
interface button_conditioner_if #(
  parameter int N_BTN = 5
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_pulse;

  modport master (output btn_raw, input btn_level, input btn_pulse);
  modport slave  (input btn_raw, output btn_level, output btn_pulse);
endinterface

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronise, debounce and pulse-convert push buttons
// Purpose: per channel, a 2-FF synchroniser feeds a debounce counter; an accepted
//          press produces a registered one-cycle pulse on the cycle the level rises.
// Ports:   CLK_50MHZ  system clock, rising edge
//          reset      asynchronous active-low reset
//          btn_if     slave side of button_conditioner_if (btn_raw in, btn_level/btn_pulse out)
// Option:  define BUTTON_AUTOREPEAT_EN to add a per-channel auto-repeat FSM on the
//          channels selected by REPEAT_MASK.
module button_conditioner #(
  parameter int               N_BTN           = 5,
  parameter int               DEBOUNCE_CYCLES = 1000000,
  parameter int               REPEAT_DELAY    = 25000000,
  parameter int               REPEAT_PERIOD   = 5000000,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(5'b11000)
) (
  input  logic                 CLK_50MHZ,
  input  logic                 reset,
  button_conditioner_if.slave  btn_if
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCNT_W = $clog2(RMAX + 1);
  localparam logic [RCNT_W-1:0] RDLY_LAST = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RPER_LAST = RCNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_MASK, REPEAT_DELAY[0], REPEAT_PERIOD[0]};
`endif

  logic [N_BTN-1:0] level_vec;
  logic [N_BTN-1:0] pulse_vec;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic             s1_q, s2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q;
    logic             rise;

    // The counter only runs while the synchronised input disagrees with the
    // accepted level; any sample matching the level restarts the window.
    always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (s2_q != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_d = s2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    assign rise = level_d & ~level_q;

    always_ff @(posedge CLK_50MHZ or negedge reset) begin
      if (!reset) begin
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        level_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        s1_q    <= btn_if.btn_raw[i];
        s2_q    <= s1_q;
        level_q <= level_d;
        cnt_q   <= cnt_d;
      end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    if (REPEAT_MASK[i]) begin : g_rpt
      rpt_state_e        state_q;
      logic [RCNT_W-1:0] rcnt_q;

      // A release (or any cycle with the level low) returns to IDLE without a pulse.
      always_ff @(posedge CLK_50MHZ or negedge reset) begin
        if (!reset) begin
          state_q <= RPT_IDLE;
          rcnt_q  <= '0;
          pulse_q <= 1'b0;
        end else begin
          pulse_q <= rise;
          if (!level_d) begin
            state_q <= RPT_IDLE;
            rcnt_q  <= '0;
          end else begin
            case (state_q)
              RPT_IDLE: begin
                rcnt_q <= '0;
                if (rise) state_q <= RPT_DELAY;
              end
              RPT_DELAY: begin
                if (rcnt_q == RDLY_LAST) begin
                  pulse_q <= 1'b1;
                  state_q <= RPT_REPEAT;
                  rcnt_q  <= '0;
                end else begin
                  rcnt_q <= rcnt_q + 1'b1;
                end
              end
              RPT_REPEAT: begin
                if (rcnt_q == RPER_LAST) begin
                  pulse_q <= 1'b1;
                  rcnt_q  <= '0;
                end else begin
                  rcnt_q <= rcnt_q + 1'b1;
                end
              end
              default: begin
                state_q <= RPT_IDLE;
                rcnt_q  <= '0;
              end
            endcase
          end
        end
      end
    end else begin : g_norpt
      always_ff @(posedge CLK_50MHZ or negedge reset) begin
        if (!reset) pulse_q <= 1'b0;
        else        pulse_q <= rise;
      end
    end
`else
    always_ff @(posedge CLK_50MHZ or negedge reset) begin
      if (!reset) pulse_q <= 1'b0;
      else        pulse_q <= rise;
    end
`endif

    assign level_vec[i] = level_q;
    assign pulse_vec[i] = pulse_q;
  end

  assign btn_if.btn_level = level_vec;
  assign btn_if.btn_pulse = pulse_vec;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - self-checking bench for button_conditioner
module tb_button_conditioner;
  localparam int N   = 5;
  localparam int DB  = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;
  localparam logic [N-1:0] MASK = 5'b11000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  button_conditioner_if #(.N_BTN(N)) bif ();

  button_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP), .REPEAT_MASK(MASK)
  ) dut (
    .CLK_50MHZ(clk),
    .reset(rst_n),
    .btn_if(bif.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model state: raw value seen at each edge since reset release
  logic [N-1:0] hist[$];
  logic [N-1:0] m_level;
  logic [N-1:0] m_pulse;
  bit           held[N];
  int           age[N];
  int           pcnt[N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic hs(int m, int ch);
    if (m < 0 || m >= hist.size()) return 1'b0;
    return hist[m][ch];
  endfunction

  function automatic bit rep_en(int ch);
`ifdef BUTTON_AUTOREPEAT_EN
    return MASK[ch];
`else
    return (ch < 0);
`endif
  endfunction

  task automatic model_reset();
    hist.delete();
    m_level = '0;
    m_pulse = '0;
    for (int c = 0; c < N; c++) begin held[c] = 0; age[c] = 0; end
  endtask

  // Level flips once the input (seen two clocks late) has disagreed with it for DB edges.
  task automatic model_edge();
    int n;
    logic [N-1:0] nl;
    hist.push_back(bif.btn_raw);
    n = hist.size() - 1;
    m_pulse = '0;
    nl = m_level;
    for (int c = 0; c < N; c++) begin
      bit acc = 1;
      for (int j = 0; j < DB; j++)
        if (hs(n - 2 - j, c) == m_level[c]) acc = 0;
      if (acc) nl[c] = ~m_level[c];
      if (nl[c] && !m_level[c]) begin
        m_pulse[c] = 1'b1; held[c] = 1; age[c] = 0;
      end else if (held[c]) begin
        if (!nl[c]) held[c] = 0;
        else begin
          age[c]++;
          if (rep_en(c) && (age[c] == RD || (age[c] > RD && (age[c] - RD) % RP == 0)))
            m_pulse[c] = 1'b1;
        end
      end
    end
    m_level = nl;
  endtask

  // One clock: drive raw, let the edge happen, compare 1 time unit later.
  task automatic step(input logic [N-1:0] raw);
    bif.btn_raw = raw;
    @(posedge clk);
    model_edge();
    #1;
    check("level", 32'(bif.btn_level), 32'(m_level));
    check("pulse", 32'(bif.btn_pulse), 32'(m_pulse));
    for (int c = 0; c < N; c++) pcnt[c] += int'(bif.btn_pulse[c]);
  endtask

  task automatic clr_cnt();
    for (int c = 0; c < N; c++) pcnt[c] = 0;
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset(input int cycles);
    #2 rst_n = 1'b0;
    #1;
    check("rst_level", 32'(bif.btn_level), 32'h0);
    check("rst_pulse", 32'(bif.btn_pulse), 32'h0);
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bif.btn_raw = 5'b11111;
    model_reset();
    clr_cnt();

    // 1: held through reset, then debounced afresh
    repeat (10) @(posedge clk);
    #1;
    check("t1_rst_level", 32'(bif.btn_level), 32'h0);
    check("t1_rst_pulse", 32'(bif.btn_pulse), 32'h0);
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step(5'b11111);
      if (i == 5) check("t1_level_pre", 32'(bif.btn_level), 32'h0);
      if (i == 6) begin
        check("t1_level", 32'(bif.btn_level), 32'h1f);
        check("t1_pulse", 32'(bif.btn_pulse), 32'h1f);
      end
    end
    repeat (12) step(5'b00000);
    check("t1_released", 32'(bif.btn_level), 32'h0);

    // 2: single press on ch0, release gives no pulse
    clr_cnt();
    for (int i = 1; i <= 10; i++) begin
      step(5'b00001);
      if (i == 6) check("t2_pulse0", 32'(bif.btn_pulse), 32'h1);
    end
    check("t2_level0", 32'(bif.btn_level[0]), 32'h1);
    for (int i = 1; i <= 6; i++) begin
      step(5'b00000);
      if (i == 5) check("t2_rel_hold", 32'(bif.btn_level[0]), 32'h1);
      if (i == 6) check("t2_rel_level", 32'(bif.btn_level[0]), 32'h0);
    end
    check("t2_npulse", 32'(pcnt[0]), 32'd1);

    // 3: bouncing ch1 never accepted
    clr_cnt();
    for (int r = 0; r < 3; r++) begin
      step(5'b00010); step(5'b00010); step(5'b00010); step(5'b00000);
    end
    repeat (4) step(5'b00000);
    check("t3_npulse1", 32'(pcnt[1]), 32'd0);

    // 4: ch2/ch3 together, ch2 released early
    clr_cnt();
    for (int i = 1; i <= 6; i++) begin
      step(5'b01100);
      if (i == 6) check("t4_pulse23", 32'(bif.btn_pulse), 32'h0c);
    end
    repeat (3) step(5'b01000);
    repeat (6) step(5'b01000);
    check("t4_level", 32'(bif.btn_level), 32'h08);
    repeat (8) step(5'b00000);

    // 5: reset mid-debounce on ch0 restarts the window
    repeat (4) step(5'b00001);
    do_reset(2);
    for (int i = 1; i <= 6; i++) begin
      step(5'b00001);
      if (i == 5) check("t5_level_pre", 32'(bif.btn_level[0]), 32'h0);
      if (i == 6) check("t5_pulse0", 32'(bif.btn_pulse[0]), 32'h1);
    end
    repeat (8) step(5'b00000);

    // 6: long hold on ch4 and ch0
    clr_cnt();
    repeat (40) step(5'b10001);
`ifdef BUTTON_AUTOREPEAT_EN
    check("t6_npulse4", 32'(pcnt[4]), 32'd10);
`else
    check("t6_npulse4", 32'(pcnt[4]), 32'd1);
`endif
    check("t6_npulse0", 32'(pcnt[0]), 32'd1);
    repeat (8) step(5'b00000);

    // random holds per channel, with occasional resets
    begin
      logic [N-1:0] cur;
      int remain[N];
      cur = '0;
      for (int c = 0; c < N; c++) remain[c] = 0;
      for (int t = 0; t < 1500; t++) begin
        for (int c = 0; c < N; c++) begin
          if (remain[c] == 0) begin
            cur[c] = ~cur[c];
            remain[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                     : $urandom_range(4, 30);
          end
          remain[c]--;
        end
        if ($urandom_range(0, 299) == 0) do_reset($urandom_range(1, 3));
        step(cur);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
